// File: rtl/keypad_if.sv
// Keypad scanner signal bundle.
// master drives rows and clear, slave returns strobes and decoded keys.
interface keypad_if;
  logic [3:0]  row;
  logic        clr;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        pressed;
  logic [15:0] value;

  modport master (
    output row, clr,
    input  col, key_valid, key_code, pressed, value
  );

  modport slave (
    input  row, clr,
    output col, key_valid, key_code, pressed, value
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with frame debounce.
// Accepted hex digits shift into a 4-digit display value.
module keypad_scan #(
  parameter int SCAN_DIV       = 65536,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic     clk,
  input logic     reset,
  keypad_if.slave kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2
  } state_t;

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] div;
  logic [1:0]    cidx;
  logic          sample, done;

  logic [1:0]    acc_n;
  logic [3:0]    acc_code;
  logic [1:0]    smp_n;
  logic [1:0]    smp_r;
  logic [2:0]    tot;
  logic [3:0]    f_code;
  logic          f_none, f_one;

  state_t        state, state_nx;
  logic [3:0]    cand, cand_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          accept, release_k;

  assign kp.col = ~(4'b0001 << cidx);
  assign sample = (div == DW'(SCAN_DIV - 1));
  assign done   = sample && (cidx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
      div    <= '0;
      cidx   <= 2'd0;
    end else begin
      row_s1 <= kp.row;
      row_s2 <= row_s1;
      if (sample) begin
        div  <= '0;
        cidx <= cidx + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // Count low rows in this column sample, saturating at two.
  always_comb begin
    smp_n = 2'd0;
    smp_r = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        if (smp_n != 2'd2) smp_n = smp_n + 2'd1;
        smp_r = 2'(r);
      end
    end
  end

  always_comb begin
    tot    = {1'b0, acc_n} + {1'b0, smp_n};
    f_code = (smp_n == 2'd1) ? {smp_r, cidx} : acc_code;
    f_none = (tot == 3'd0);
    f_one  = (tot == 3'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_n    <= 2'd0;
      acc_code <= 4'd0;
    end else if (sample) begin
      if (cidx == 2'd3) begin
        acc_n    <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_n    <= (tot >= 3'd2) ? 2'd2 : tot[1:0];
        acc_code <= f_code;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cand  <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      cnt   <= cnt_nx;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    if (done) begin
      case (state)
        IDLE: begin
          if (f_one) begin
            cand_nx  = f_code;
            cnt_nx   = CW'(1);
            state_nx = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (f_one && f_code == cand) begin
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_nx = HELD;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else if (f_one) begin
            cand_nx = f_code;
            cnt_nx  = CW'(1);
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
        HELD: begin
          if (f_none) begin
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            cnt_nx = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_comb begin
    accept    = 1'b0;
    release_k = 1'b0;
    if (done && state == PRESS_DB && f_one &&
        f_code == cand && cnt_inc == CW'(DEBOUNCE_SCANS))
      accept = 1'b1;
    if (done && state == HELD && f_none &&
        cnt_inc == CW'(DEBOUNCE_SCANS))
      release_k = 1'b1;
  end

  // Clear beats a coincident accept for value only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kp.key_valid <= 1'b0;
      kp.key_code  <= 4'd0;
      kp.pressed   <= 1'b0;
      kp.value     <= 16'h0000;
    end else begin
      kp.key_valid <= accept;
      if (accept) kp.key_code <= cand;
      if (accept) kp.pressed <= 1'b1;
      else if (release_k) kp.pressed <= 1'b0;
      if (kp.clr) kp.value <= 16'h0000;
      else if (accept) kp.value <= {kp.value[11:0], cand};
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a keypad matrix model.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] keys;
  logic        seen_p;
  int          total = 0;
  int          bad = 0;
  int          nvalid = 0;

  keypad_if kp ();

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic [3:0] rv;
    rv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !kp.col[c]) rv[r] = 1'b0;
    kp.row = rv;
  end

  always @(negedge clk)
    if (kp.key_valid === 1'b1) nvalid++;

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (kp.pressed === 1'b1) seen_p = 1'b1;
    end
  endtask

  task automatic sync_frame();
    logic [3:0] pc;
    logic ok;
    ok = 1'b0;
    pc = kp.col;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (kp.col == 4'b1110 && pc == 4'b0111) ok = 1'b1;
      pc = kp.col;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL sync_frame: no frame start within 40 cycles");
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    reset = 1'b1;
    keys  = 16'h0;
    kp.clr = 1'b0;
    repeat (3) @(negedge clk);
    total += 5;
    if (kp.col !== 4'b1110) begin
      bad++; $display("FAIL rst_col: got %b want 1110", kp.col);
    end
    if (kp.key_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid: got %b want 0", kp.key_valid);
    end
    if (kp.key_code !== 4'h0) begin
      bad++; $display("FAIL rst_code: got %h want 0", kp.key_code);
    end
    if (kp.pressed !== 1'b0) begin
      bad++; $display("FAIL rst_pressed: got %b want 0", kp.pressed);
    end
    if (kp.value !== 16'h0) begin
      bad++; $display("FAIL rst_value: got %h want 0000", kp.value);
    end
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp = ~(4'b0001 << ((k / 4) % 4));
      total += 2;
      if (kp.col !== exp) begin
        bad++;
        $display("FAIL rotate k=%0d: got %b want %b", k, kp.col, exp);
      end
      if (kp.key_valid !== 1'b0) begin
        bad++; $display("FAIL idle_valid k=%0d: got %b want 0", k, kp.key_valid);
      end
    end
  endtask

  task automatic test_press();
    int v0;
    sync_frame();
    v0 = nvalid;
    keys = 16'h1 << 6;
    run(6 * 16);
    keys = 16'h0;
    total++;
    if (kp.pressed !== 1'b1) begin
      bad++; $display("FAIL press_held: got %b want 1", kp.pressed);
    end
    run(2 * 16);
    total++;
    if (kp.pressed !== 1'b1) begin
      bad++; $display("FAIL press_2empty: got %b want 1", kp.pressed);
    end
    run(2 * 16);
    total += 4;
    if (kp.pressed !== 1'b0) begin
      bad++; $display("FAIL press_release: got %b want 0", kp.pressed);
    end
    if (nvalid - v0 != 1) begin
      bad++; $display("FAIL press_count: got %0d want 1", nvalid - v0);
    end
    if (kp.key_code !== 4'h6) begin
      bad++; $display("FAIL press_code: got %h want 6", kp.key_code);
    end
    if (kp.value !== 16'h0006) begin
      bad++; $display("FAIL press_value: got %h want 0006", kp.value);
    end
  endtask

  task automatic test_sequence();
    int v0;
    v0 = nvalid;
    for (int i = 1; i <= 4; i++) begin
      sync_frame();
      keys = 16'h1 << i;
      run(5 * 16);
      keys = 16'h0;
      run(4 * 16);
      total++;
      if (kp.key_code !== 4'(i)) begin
        bad++; $display("FAIL seq_code%0d: got %h want %0d", i, kp.key_code, i);
      end
    end
    total += 2;
    if (nvalid - v0 != 4) begin
      bad++; $display("FAIL seq_count: got %0d want 4", nvalid - v0);
    end
    if (kp.value !== 16'h1234) begin
      bad++; $display("FAIL seq_value: got %h want 1234", kp.value);
    end
  endtask

  task automatic test_bounce();
    int v0;
    sync_frame();
    v0 = nvalid;
    seen_p = 1'b0;
    keys = 16'h1 << 8; run(2 * 16);
    keys = 16'h0;      run(1 * 16);
    keys = 16'h1 << 8; run(2 * 16);
    keys = 16'h0;      run(4 * 16);
    total += 2;
    if (nvalid - v0 != 0) begin
      bad++; $display("FAIL bounce_count: got %0d want 0", nvalid - v0);
    end
    if (seen_p !== 1'b0) begin
      bad++; $display("FAIL bounce_pressed: got %b want 0", seen_p);
    end
  endtask

  task automatic test_ghost();
    int v0;
    sync_frame();
    v0 = nvalid;
    keys = (16'h1 << 0) | (16'h1 << 11);
    run(6 * 16);
    total += 2;
    if (nvalid - v0 != 0) begin
      bad++; $display("FAIL multi_count: got %0d want 0", nvalid - v0);
    end
    if (kp.pressed !== 1'b0) begin
      bad++; $display("FAIL multi_pressed: got %b want 0", kp.pressed);
    end
    keys = 16'h1 << 15;
    run(5 * 16);
    keys = 16'h0;
    total += 3;
    if (nvalid - v0 != 1) begin
      bad++; $display("FAIL r3c3_count: got %0d want 1", nvalid - v0);
    end
    if (kp.key_code !== 4'hF) begin
      bad++; $display("FAIL r3c3_code: got %h want f", kp.key_code);
    end
    if (kp.value !== 16'h234F) begin
      bad++; $display("FAIL r3c3_value: got %h want 234f", kp.value);
    end
    run(4 * 16);
  endtask

  task automatic test_clr_reset();
    int v0;
    sync_frame();
    keys = 16'h1 << 5;
    run(47);
    kp.clr = 1'b1;
    @(negedge clk);
    kp.clr = 1'b0;
    total += 3;
    if (kp.key_valid !== 1'b1) begin
      bad++; $display("FAIL clr_valid: got %b want 1", kp.key_valid);
    end
    if (kp.key_code !== 4'h5) begin
      bad++; $display("FAIL clr_code: got %h want 5", kp.key_code);
    end
    if (kp.value !== 16'h0000) begin
      bad++; $display("FAIL clr_value: got %h want 0000", kp.value);
    end
    run(16);
    #2 reset = 1'b1;
    #1;
    total += 4;
    if (kp.col !== 4'b1110) begin
      bad++; $display("FAIL arst_col: got %b want 1110", kp.col);
    end
    if (kp.pressed !== 1'b0) begin
      bad++; $display("FAIL arst_pressed: got %b want 0", kp.pressed);
    end
    if (kp.key_code !== 4'h0) begin
      bad++; $display("FAIL arst_code: got %h want 0", kp.key_code);
    end
    if (kp.value !== 16'h0000) begin
      bad++; $display("FAIL arst_value: got %h want 0000", kp.value);
    end
    @(negedge clk);
    reset = 1'b0;
    v0 = nvalid;
    run(47);
    total++;
    if (kp.key_valid !== 1'b0) begin
      bad++; $display("FAIL rearm_early: got %b want 0", kp.key_valid);
    end
    @(negedge clk);
    total += 3;
    if (kp.key_valid !== 1'b1) begin
      bad++; $display("FAIL rearm_valid: got %b want 1", kp.key_valid);
    end
    if (kp.key_code !== 4'h5) begin
      bad++; $display("FAIL rearm_code: got %h want 5", kp.key_code);
    end
    if (kp.value !== 16'h0005) begin
      bad++; $display("FAIL rearm_value: got %h want 0005", kp.value);
    end
    run(2 * 16);
    keys = 16'h0;
    run(4 * 16);
    total++;
    if (nvalid - v0 != 1) begin
      bad++; $display("FAIL rearm_count: got %0d want 1", nvalid - v0);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_sequence();
    test_bounce();
    test_ghost();
    test_clr_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
